// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and
// the nibble index width helper.
package nibble_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIBBLE_W = 4;

    // A single-nibble adder still needs a 1-bit index register
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla_4b.sv
// 4-bit carry-lookahead slice; the serial adder reuses one of these per nibble.
module cla_4b
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] s,
    output logic                c_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded from c_in directly so no ripple path exists
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s     = p ^ c[3:0];
    assign c_out = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one cla_4b slice walks the operands a nibble per
// clock, LSB first, with a registered carry between nibbles.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_s,
    output logic         o_c,
    output logic         o_ovf
);

    localparam int N  = W / 4;
    localparam int IW = idx_width(N);

    if (((W % 4) != 0) || (W < 4)) begin : g_bad_width
        $error("nibble_serial_adder: W must be a multiple of 4 and at least 4");
    end

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  s_q;
    logic          c_q;
    logic          ovf_q;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    slice_s;
    logic          slice_c;
    logic          last_nib;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    assign last_nib = (idx == IW'(N - 1));

    cla_4b u_slice (
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        carry_q <= i_c;
                        idx     <= '0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IW'(i)) begin
                            s_q[4*i +: 4] <= slice_s;
                        end
                    end
                    carry_q <= slice_c;
                    // Overflow = carry into the MSB xor carry out of the MSB
                    if (last_nib) begin
                        c_q   <= slice_c;
                        ovf_q <= a_q[W-1] ^ b_q[W-1] ^ slice_s[3] ^ slice_c;
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);
    assign o_s     = s_q;
    assign o_c     = c_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at W=16, finishing
// with a randomised back-to-back run against a 17-bit reference sum.
module tb_nibble_serial_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_c;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_s;
    logic         o_c;
    logic         o_ovf;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [4] = '{
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1}
    };

    always #5 i_clk = ~i_clk;

    nibble_serial_adder #(.W(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_c     (i_c),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_s     (o_s),
        .o_c     (o_c),
        .o_ovf   (o_ovf)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Presents one operand set, waits for acceptance, then counts edges to o_valid
    task automatic issue_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, output int lat, output bit timed_out);
        int guard;
        guard   = 0;
        i_a     = a;
        i_b     = b;
        i_c     = c;
        i_valid = 1'b1;
        while (!o_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 50) begin
            tick();
            lat++;
        end
        timed_out = !o_valid;
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_c     = 1'b0;
        repeat (2) tick();
        checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_handshake: got ready/valid=%b required 10", {o_ready, o_valid});
        end
        checks++;
        if ({o_s, o_c, o_ovf} !== {16'h0000, 2'b00}) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got s=%h c=%b ovf=%b required 0000/0/0", o_s, o_c, o_ovf);
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        bit to;
        i_ready = 1'b1;
        issue_and_wait(16'h1234, 16'h4321, 1'b0, lat, to);
        checks++;
        if (to || lat != 4) begin
            failures++;
            $display("[TB] FAIL basic_latency: got %0d edges (timeout=%0b) required 4", lat, to);
        end
        checks++;
        if (o_s !== 16'h5555) begin
            failures++;
            $display("[TB] FAIL basic_sum: got %h required 5555", o_s);
        end
        checks++;
        if ({o_c, o_ovf} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL basic_flags: got c/ovf=%b required 00", {o_c, o_ovf});
        end
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_ready_in_done: got %b required 0", o_ready);
        end
        tick();
        checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL basic_release: got ready/valid=%b required 10", {o_ready, o_valid});
        end
    endtask

    task automatic test_carry_ripple();
        int lat;
        bit to;
        i_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue_and_wait(vecs[k].a, vecs[k].b, vecs[k].c, lat, to);
            checks++;
            if (to || {o_s, o_c, o_ovf} !== {vecs[k].s, vecs[k].co, vecs[k].ov}) begin
                failures++;
                $display("[TB] FAIL carry_ripple_%0d: got s=%h c=%b ovf=%b required s=%h c=%b ovf=%b",
                         k, o_s, o_c, o_ovf, vecs[k].s, vecs[k].co, vecs[k].ov);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        int lat;
        bit to;
        i_ready = 1'b1;
        for (int k = 2; k < 4; k++) begin
            issue_and_wait(vecs[k].a, vecs[k].b, vecs[k].c, lat, to);
            checks++;
            if (to || {o_s, o_c, o_ovf} !== {vecs[k].s, vecs[k].co, vecs[k].ov}) begin
                failures++;
                $display("[TB] FAIL overflow_%0d: got s=%h c=%b ovf=%b required s=%h c=%b ovf=%b",
                         k, o_s, o_c, o_ovf, vecs[k].s, vecs[k].co, vecs[k].ov);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        i_ready = 1'b0;
        issue_and_wait(16'h0F0F, 16'h1010, 1'b1, lat, to);
        checks++;
        if (to || {o_s, o_c, o_ovf} !== {16'h1F20, 2'b00}) begin
            failures++;
            $display("[TB] FAIL bp_first_result: got s=%h c=%b ovf=%b required 1F20/0/0", o_s, o_c, o_ovf);
        end
        i_a     = 16'hAAAA;
        i_b     = 16'h5555;
        i_c     = 1'b1;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({o_valid, o_ready, o_s, o_c, o_ovf} !== {2'b10, 16'h1F20, 2'b00}) begin
                failures++;
                $display("[TB] FAIL bp_hold_%0d: got valid=%b ready=%b s=%h c=%b ovf=%b required 1/0/1F20/0/0",
                         k, o_valid, o_ready, o_s, o_c, o_ovf);
            end
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL bp_release: got ready/valid=%b required 10", {o_ready, o_valid});
        end
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_accept: got ready=%b required 0", o_ready);
        end
        lat = 0;
        while (!o_valid && lat < 50) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 4 || {o_s, o_c, o_ovf} !== {16'h0000, 2'b10}) begin
            failures++;
            $display("[TB] FAIL bp_second_result: got lat=%0d s=%h c=%b ovf=%b required 4/0000/1/0",
                     lat, o_s, o_c, o_ovf);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        i_ready = 1'b0;
        i_a     = 16'h1234;
        i_b     = 16'h1111;
        i_c     = 1'b0;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if ({o_ready, o_valid, o_s, o_c, o_ovf} !== {2'b10, 16'h0000, 2'b00}) begin
            failures++;
            $display("[TB] FAIL reset_mid_abort: got ready=%b valid=%b s=%h c=%b ovf=%b required 1/0/0000/0/0",
                     o_ready, o_valid, o_s, o_c, o_ovf);
        end
        i_ready = 1'b1;
        issue_and_wait(16'h00FF, 16'h0001, 1'b0, lat, to);
        checks++;
        if (to || {o_s, o_c, o_ovf} !== {16'h0100, 2'b00}) begin
            failures++;
            $display("[TB] FAIL reset_mid_followup: got s=%h c=%b ovf=%b required 0100/0/0", o_s, o_c, o_ovf);
        end
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] exp_q [$];
        int received;
        bit drv_to;
        received = 0;
        drv_to   = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    logic [W-1:0] a;
                    logic [W-1:0] b;
                    logic         c;
                    logic [W:0]   full;
                    logic         ov;
                    int           idle;
                    int           g;
                    bit           acc;
                    a    = W'($urandom);
                    b    = W'($urandom);
                    c    = 1'($urandom_range(0, 1));
                    idle = $urandom_range(0, 2);
                    repeat (idle) tick();
                    i_a     = a;
                    i_b     = b;
                    i_c     = c;
                    i_valid = 1'b1;
                    g       = 0;
                    acc     = 1'b0;
                    while (!acc && g < 200) begin
                        acc = o_ready;
                        tick();
                        g++;
                    end
                    i_valid = 1'b0;
                    if (!acc) begin
                        drv_to = 1'b1;
                    end else begin
                        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
                        ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
                        exp_q.push_back({ov, full});
                    end
                end
            end
            begin
                int cyc;
                logic [W+1:0] exp;
                cyc = 0;
                while (received < 200 && cyc < 20000) begin
                    i_ready = ($urandom_range(0, 3) != 0);
                    if (o_valid && i_ready) begin
                        exp = (exp_q.size() > 0) ? exp_q.pop_front() : {(W+2){1'bx}};
                        checks++;
                        if ({o_ovf, o_c, o_s} !== exp) begin
                            failures++;
                            $display("[TB] FAIL b2b_result_%0d: got ovf=%b c=%b s=%h required ovf=%b c=%b s=%h",
                                     received, o_ovf, o_c, o_s, exp[W+1], exp[W], exp[W-1:0]);
                        end
                        received++;
                    end
                    tick();
                    cyc++;
                end
                i_ready = 1'b0;
            end
        join
        checks++;
        if (received != 200 || drv_to || exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL b2b_count: got received=%0d leftover=%0d driver_timeout=%0b required 200/0/0",
                     received, exp_q.size(), drv_to);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ripple();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
